// File: rtl/rram_pkg.sv
// Shared definitions for the RRAM controller: host op codes, sequencer
// state encoding and the op -> mode-select decode.
package rram_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_FORM  = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_RUN   = 3'd2,
    S_HOLD  = 3'd3,
    S_ERR   = 3'd4
  } state_e;

  // One-hot mode selects presented to state_counter.
  typedef struct packed {
    logic re;
    logic we;
    logic forming;
  } mode_t;

  function automatic mode_t op_mode(op_e op);
    mode_t m;
    m = '0;
    case (op)
      OP_READ:  m.re      = 1'b1;
      OP_WRITE: m.we      = 1'b1;
      OP_FORM:  m.forming = 1'b1;
      default:  m         = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/rram_op_ctrl_if.sv
// Host command channel of the operation sequencer: one command at a time,
// accepted on cmd_valid & cmd_ready, completion reported by done/err pulses.
interface rram_op_ctrl_if;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic       cmd_ready;
  logic       abort;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output cmd_valid, cmd_op, abort,
    input  cmd_ready, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_op, abort,
    output cmd_ready, busy, done, err
  );
endinterface

// File: rtl/rram_tmo_cnt.sv
// Loadable up-counter with clear, increment enable and a terminal-count
// flag against a run-time terminal value. Shared by the SETUP and RUN phases.
module rram_tmo_cnt #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic         tc
);

  logic [W-1:0] cnt;

  // Count register: clear beats load beats increment.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (inc)
      cnt <= cnt + W'(1);
  end

  assign tc = (cnt == term);

endmodule

// File: rtl/rram_op_ctrl.sv
// Operation sequencer upstream of state_counter: takes one READ / WRITE /
// FORMING command, sequences CE/mode setup, the counted RUN phase and a
// one-cycle HOLD, and reports done, or err on timeout / abort / reserved op.
module rram_op_ctrl
  import rram_pkg::*;
#(
  parameter int SETUP_CYC = 2,
  parameter int TIMEOUT   = 64,
  parameter int TMO_W     = 7
) (
  input  logic           clk,
  input  logic           rst,
  rram_op_ctrl_if.slave  host,
  input  logic           cache_count_flag,
  input  logic           write_count_flag,
  input  logic           forming_count_flag,
  output logic           en,
  output logic           CE,
  output logic           RE,
  output logic           we,
  output logic           re,
  output logic           forming,
  output logic           RE_L,
  output logic           WE_L
);

  localparam logic [TMO_W-1:0] SETUP_TERM = TMO_W'(SETUP_CYC - 1);
  localparam logic [TMO_W-1:0] RUN_TERM   = TMO_W'(TIMEOUT - 1);

  state_e state;
  op_e    op_q;
  op_e    cmd_op;
  logic   done_q;
  logic   err_q;
  logic   flag_hit;
  logic   to_err;
  logic   tc;

  assign cmd_op = op_e'(host.cmd_op);

  // Only the count flag belonging to the latched op can complete RUN.
  // NOTE: every always_comb output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    flag_hit = 1'b0;
    case (op_q)
      OP_READ:  flag_hit = cache_count_flag;
      OP_WRITE: flag_hit = write_count_flag;
      OP_FORM:  flag_hit = forming_count_flag;
      default:  flag_hit = 1'b0;
    endcase
  end

  // Error entry: abort during SETUP/RUN, reserved op, or RUN timeout with
  // no matching flag (a flag on the last allowed cycle still completes).
  assign to_err = ((state == S_SETUP || state == S_RUN) && host.abort) ||
                  (state == S_IDLE && host.cmd_valid && cmd_op == OP_RSVD) ||
                  (state == S_RUN && tc && !flag_hit);

  rram_tmo_cnt #(.W(TMO_W)) u_tmo_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (state == S_IDLE),
    .load     (state == S_SETUP && tc),
    .load_val ('0),
    .inc      (state == S_SETUP || state == S_RUN),
    .term     ((state == S_SETUP) ? SETUP_TERM : RUN_TERM),
    .tc       (tc)
  );

  // Sequencer FSM with all array/host pulse outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      op_q    <= OP_READ;
      en      <= 1'b0;
      CE      <= 1'b0;
      RE      <= 1'b0;
      we      <= 1'b0;
      re      <= 1'b0;
      forming <= 1'b0;
      RE_L    <= 1'b1;
      WE_L    <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (to_err) begin
        state   <= S_ERR;
        err_q   <= 1'b1;
        en      <= 1'b0;
        CE      <= 1'b0;
        RE      <= 1'b0;
        we      <= 1'b0;
        re      <= 1'b0;
        forming <= 1'b0;
        RE_L    <= 1'b1;
        WE_L    <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (host.cmd_valid) begin
              op_q                <= cmd_op;
              state               <= S_SETUP;
              CE                  <= 1'b1;
              {re, we, forming}   <= op_mode(cmd_op);
              RE                  <= (cmd_op == OP_READ);
            end
          end
          S_SETUP: begin
            if (tc) begin
              state <= S_RUN;
              en    <= 1'b1;
              WE_L  <= (op_q != OP_READ);
              RE_L  <= (op_q != OP_WRITE);
            end
          end
          S_RUN: begin
            if (flag_hit) begin
              state <= S_HOLD;
              en    <= 1'b0;
              RE_L  <= 1'b1;
              WE_L  <= 1'b1;
            end
          end
          S_HOLD: begin
            state   <= S_IDLE;
            done_q  <= 1'b1;
            CE      <= 1'b0;
            RE      <= 1'b0;
            we      <= 1'b0;
            re      <= 1'b0;
            forming <= 1'b0;
          end
          S_ERR:   state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign host.cmd_ready = (state == S_IDLE);
  assign host.busy      = (state != S_IDLE);
  assign host.done      = done_q;
  assign host.err       = err_q;

endmodule
